// File: rtl/sipo_pkg.sv
// Shared types and line levels for the framed SIPO receiver.
// Frame on the wire: start bit (1), WIDTH data bits MSB first, stop bit (0).
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STOP  = 2'b10
  } rx_state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Serial-in / parallel-out bundle between the receiver and its consumer.
// master = receiver controller, slave = line driver plus parallel consumer.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    input  din,
    input  dout_ready,
    output dout,
    output dout_valid,
    output busy,
    output frame_err,
    output overrun
  );

  modport slave (
    output din,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/sipo_shreg.sv
// Left-shifting SIPO register; new bit enters at the LSB so the first
// (MSB-first) data bit ends up in q[WIDTH-1] after WIDTH shifts.
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial receiver: sequences sipo_shreg, checks the stop bit and
// hands the word to a one-deep valid/ready holding register.
//
// state | meaning
// IDLE  | waiting for a start bit on din
// SHIFT | shifting data bits, cnt counts bits taken
// STOP  | sampling stop bit; load, drop (overrun) or reject (frame_err)
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sipo_rx_ctrl_if.master        bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic shift_en;
  logic load;
  logic drain;
  logic hold_free;
  logic frame_err_nxt;
  logic overrun_nxt;

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .din (bus.din),
    .q   (shreg)
  );

  // A draining word frees the holding register on the same edge.
  assign drain     = dout_valid_q && bus.dout_ready;
  assign hold_free = !dout_valid_q || bus.dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shift_en      = 1'b0;
    load          = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.din == START_LVL) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        state_nxt = IDLE;
        if (bus.din == STOP_LVL) begin
          if (hold_free) begin
            load = 1'b1;
          end else begin
            overrun_nxt = 1'b1;
          end
        end else begin
          frame_err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= frame_err_nxt;
      overrun_q   <= overrun_nxt;
      if (load) begin
        dout_q       <= shreg;
        dout_valid_q <= 1'b1;
      end else if (drain) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_sipo_rx_ctrl;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] exp_dout;
  logic         exp_valid;
  logic         exp_fe;
  logic         exp_ov;
  logic         exp_busy;

  sipo_rx_ctrl_if #(.WIDTH(W)) bus ();

  sipo_rx_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},       32'(bus.dout),       32'(exp_dout));
    check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(exp_valid));
    check({tag, ".busy"},       32'(bus.busy),       32'(exp_busy));
    check({tag, ".frame_err"},  32'(bus.frame_err),  32'(exp_fe));
    check({tag, ".overrun"},    32'(bus.overrun),    32'(exp_ov));
  endtask

  // One clock: drive at negedge, predict the edge, compare 1ns after it.
  // For a stop edge, word/stopb describe the frame that just finished.
  task automatic cycle(input string tag, input logic d, input logic r, input logic busy_after,
                       input logic is_stop, input logic [W-1:0] word);
    logic room;
    @(negedge clk);
    bus.din        = d;
    bus.dout_ready = r;
    room   = !exp_valid || r;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (is_stop && d == 1'b1) begin
      exp_fe = 1'b1;
      if (exp_valid && r) exp_valid = 1'b0;
    end else if (is_stop && room) begin
      exp_dout  = word;
      exp_valid = 1'b1;
    end else begin
      if (is_stop) exp_ov = 1'b1;
      if (exp_valid && r) exp_valid = 1'b0;
    end
    exp_busy = busy_after;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // rdy_mode: 0 = never ready, 1 = random, 2 = ready only on the stop edge
  task automatic send_frame(input string tag, input logic [W-1:0] word, input logic stopb,
                            input int rdy_mode);
    logic r;
    r = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    cycle({tag, ".start"}, 1'b1, r, 1'b1, 1'b0, word);
    for (int i = W - 1; i >= 0; i--) begin
      r = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle({tag, ".data"}, word[i], r, 1'b1, 1'b0, word);
    end
    r = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
    cycle({tag, ".stop"}, stopb, r, 1'b0, 1'b1, word);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_fe    = 1'b0;
    exp_ov    = 1'b0;
    exp_busy  = 1'b0;
    rst            = 1'b1;
    bus.din        = 1'b0;
    bus.dout_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cycle("idle", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
    end

    // bad stop: din 1,0,1,1,0,1
    send_frame("badstop", 4'b0110, 1'b1, 0);
    check("badstop.fe_pulse", 32'(bus.frame_err), 32'd1);
    cycle("badstop.after", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("badstop.fe_cleared", 32'(bus.frame_err), 32'd0);
    check("badstop.dout_zero", 32'(bus.dout), 32'd0);

    // good frame: din 1,1,0,1,1,0
    send_frame("good", 4'b1011, 1'b0, 0);
    check("good.dout_const", 32'(bus.dout), 32'hb);
    check("good.valid_const", 32'(bus.dout_valid), 32'd1);
    cycle("good.drain", 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // overrun: 1010 then 0101 back-to-back, never ready
    send_frame("ovr1", 4'b1010, 1'b0, 0);
    send_frame("ovr2", 4'b0101, 1'b0, 0);
    check("ovr.pulse", 32'(bus.overrun), 32'd1);
    check("ovr.dout_kept", 32'(bus.dout), 32'ha);
    cycle("ovr.after", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // simultaneous drain and load while 1010 is still held
    send_frame("simul", 4'b0110, 1'b0, 2);
    check("simul.dout_const", 32'(bus.dout), 32'h6);
    check("simul.valid_const", 32'(bus.dout_valid), 32'd1);
    check("simul.no_ovr", 32'(bus.overrun), 32'd0);

    // reset after start plus two data bits
    cycle("rstmid.start", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle("rstmid.d0", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle("rstmid.d1", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_fe    = 1'b0;
    exp_ov    = 1'b0;
    exp_busy  = 1'b0;
    check_all("rstmid.async");
    @(negedge clk);
    rst = 1'b0;
    send_frame("post_rst", 4'b1001, 1'b0, 0);
    check("post_rst.dout_const", 32'(bus.dout), 32'h9);
    cycle("post_rst.drain", 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // randomized frames, gaps of 0..2 idle cycles, random ready
    for (int f = 0; f < 40; f++) begin
      logic [W-1:0] w;
      logic         sb;
      int           gap;
      w   = W'($urandom_range(0, (1 << W) - 1));
      sb  = ($urandom_range(0, 9) == 0);
      gap = $urandom_range(0, 2);
      send_frame("rand", w, sb, 1);
      for (int g = 0; g < gap; g++) begin
        cycle("rand.gap", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Serial frame receiver controller that sequences a SIPO shift register. It watches the serial line for a start bit, enables shifting for exactly WIDTH data bits, and checks the stop bit. It then hands the parallel word to downstream logic through a one-deep valid/ready holding register. The block sits between the raw serial input and any parallel consumer, and replaces free-running SIPO use with framed, flow-controlled capture.

## Interface
- WIDTH, default 4: data bits per frame; must be ≥ 2.
- clk  in  1  system clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data.
  - Idle level 0, start bit 1, stop bit 0.
  - Data is MSB first.
- dout  out  WIDTH  held parallel word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts the word on any edge where dout_valid && dout_ready.
- busy  out  1  high while a frame is in progress (state != IDLE).
- frame_err  out  1  one-cycle pulse when a bad stop bit is seen.
- overrun  out  1  one-cycle pulse when a finished frame is dropped.

## Operation
- FSM states are IDLE, SHIFT and STOP. A bit counter cnt is $clog2(WIDTH) bits wide.
- IDLE
  - din=1 at an edge: go to SHIFT, cnt←0.
  - din=0: stay in IDLE.
- SHIFT
  - Every edge: shift_en=1, so shreg←{shreg[WIDTH-2:0], din}, and cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: go to STOP.
- STOP
  - Always returns to IDLE on the next edge.
  - din=0 and holding register free: load dout←shreg and set dout_valid.
  - Holding register counts as free if dout_valid=0, or if dout_valid && dout_ready on this same edge.
  - din=0 and holding register not free: drop the new word, keep the old dout, pulse overrun.
  - din=1: pulse frame_err, discard the word, leave dout/dout_valid unchanged.
- dout_valid clears on an edge where dout_valid && dout_ready, unless a load happens on that same edge; in that case it stays 1.
- dout never changes while dout_valid=1 except through the simultaneous drain+load case.
- shreg is not cleared between frames; every frame fully overwrites it.
- The stop bit is consumed in STOP. The earliest next start bit is sampled on the following edge, so frames can be back-to-back with no gap.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=IDLE, cnt=0, shreg=0;
  - dout=0, dout_valid=0, frame_err=0, overrun=0;
  - busy=0.
- A frame is WIDTH+2 cycles. If the start bit is sampled at edge E:
  - data bits are sampled at E+1..E+WIDTH;
  - the stop bit is sampled at E+WIDTH+1;
  - dout/dout_valid are visible after edge E+WIDTH+1.
- frame_err and overrun are registered. Each is high for exactly the one cycle after the stop-bit edge.
- busy is decoded from the state register: high from after edge E through the cycle before the return to IDLE.
- dout_ready is sampled only on rising edges. It may be asserted while dout_valid=0 with no effect.
- rst asserted mid-frame aborts the frame with no error pulse. The holding register is cleared.

## Structure
- Package sipo_pkg holds:
  - typedef enum logic [1:0] rx_state_t: IDLE=2'b00, SHIFT=2'b01, STOP=2'b10;
  - constants START_LVL=1'b1 and STOP_LVL=1'b0.
- One sub-module, sipo_shreg:
  - parameter WIDTH;
  - ports clk, rst (async active-high), en, din, q[WIDTH-1:0];
  - shifts left with din entering at the LSB when en=1.
- sipo_rx_ctrl holds the FSM, the counter, the holding register and the flags.

## Test plan
All scenarios use WIDTH=4. Drive din at the negedge.

- **Good frame.** din=1,1,0,1,1,0 with dout_ready=0. Required: dout=4'b1011 and dout_valid=1 after the 6th edge, frame_err=0, busy back to 0.
- **Bad stop bit.** din=1,0,1,1,0,1. Required: frame_err high for exactly one cycle, dout_valid stays 0, dout stays 0, FSM returns to IDLE.
- **Overrun.** Send frames 1010 then 0101 back-to-back with dout_ready=0. Required: dout stays 4'b1010, dout_valid=1, overrun pulses one cycle after the second stop edge.
- **Simultaneous drain and load.** Hold 4'b1010 valid; assert dout_ready=1 only on the second frame's stop edge (frame 0110). Required: dout=4'b0110, dout_valid stays 1, overrun=0.
- **Reset mid-frame.** Assert rst after start plus 2 data bits. Required: all outputs 0 immediately and busy=0. A following full frame 1001 yields dout=4'b1001 with no stray flags.
- **Idle line.** din=0 for 20 cycles. Required: busy=0, dout_valid=0, no flag pulses.
